// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin sharing of one 32-bit carry-look-ahead adder among NREQ requesters
// Ports: clk/rst (sync, active-high); req_valid/req_ready, req_a/req_b (32 bits per requester),
//        req_cin, req_chain per requester; resp_valid/resp_ready with resp_id, resp_sum,
//        resp_cout, resp_ovf from a single-entry registered output stage.
// Optional feature: define ADDER_RR_SCHED_CHAIN_EN for per-requester stored carries (req_chain).

module adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_g, w_p;
    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;
    // 4-bit look-ahead groups; the group carry feeds the next group
    always_comb begin
        logic       c;
        logic [3:0] gg, pp, cc;
        c = i_cin;
        gg = '0;
        pp = '0;
        cc = '0;
        o_sum = '0;
        for (int j = 0; j < 8; j++) begin
            gg = w_g[4*j +: 4];
            pp = w_p[4*j +: 4];
            cc[0] = c;
            cc[1] = gg[0] | (pp[0] & c);
            cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
            cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c);
            c = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c);
            o_sum[4*j +: 4] = pp ^ cc;
        end
        o_cout = c;
    end
endmodule

module adder_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_chain,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_sum,
    output logic              resp_cout,
    output logic              resp_ovf
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t          r_state, w_state_nxt;
    logic [IDW-1:0]  r_ptr, r_id, w_gnt, w_idx;
    logic [31:0]     r_sum, w_a, w_b, w_sum;
    logic            r_cout, r_ovf, w_found, w_can_issue, w_acc, w_cin, w_cout, w_ovf;

    assign w_can_issue = !rst & ((r_state == EMPTY) | resp_ready);
    assign w_acc       = w_found & w_can_issue;

    // lowest offset from the pointer wins, so scan offsets downwards and let later hits override
    always_comb begin
        w_found = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k >= NREQ) ? IDW'(int'(r_ptr) + k - NREQ) : IDW'(int'(r_ptr) + k);
            if (req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    assign req_ready = w_acc ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt) : '0;
    assign w_a = req_a[32*w_gnt +: 32];
    assign w_b = req_b[32*w_gnt +: 32];

`ifdef ADDER_RR_SCHED_CHAIN_EN
    logic [NREQ-1:0] r_carry;
    assign w_cin = req_chain[w_gnt] ? r_carry[w_gnt] : req_cin[w_gnt];
    always_ff @(posedge clk) begin
        if (rst) r_carry <= '0;
        else if (w_acc) r_carry[w_gnt] <= w_cout;
    end
`else
    logic w_unused_chain;
    assign w_unused_chain = ^req_chain;
    assign w_cin = req_cin[w_gnt];
`endif

    adder u_adder (.i_a(w_a), .i_b(w_b), .i_cin(w_cin), .o_sum(w_sum), .o_cout(w_cout));

    assign w_ovf = (w_a[31] == w_b[31]) & (w_sum[31] != w_a[31]);

    always_comb begin
        w_state_nxt = w_acc ? FULL : (resp_ready ? EMPTY : r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr <= '0;
            r_id <= '0;
            r_sum <= '0;
            r_cout <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
                r_id <= w_gnt;
                r_sum <= w_sum;
                r_cout <= w_cout;
                r_ovf <= w_ovf;
            end
        end
    end

    assign resp_valid = (r_state == FULL);
    assign resp_id    = r_id;
    assign resp_sum   = r_sum;
    assign resp_cout  = r_cout;
    assign resp_ovf   = r_ovf;
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: table vectors, scoreboard and corner-case sequences for adder_rr_sched
module tb_adder_rr_sched;
    localparam int N = 4;
    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_cin, req_chain;
    logic [32*N-1:0] req_a, req_b;
    logic            resp_valid, resp_ready, resp_cout, resp_ovf;
    logic [1:0]      resp_id;
    logic [31:0]     resp_sum;

    adder_rr_sched #(.NREQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_ovf(resp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] id; logic [31:0] sum; logic cout; logic ovf; } res_t;
    typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic cin; logic [31:0] sum; logic cout; logic ovf; } vec_t;
    res_t         sb[$];
    res_t         m_exp;
    vec_t         vt[7];
    logic [N-1:0] m_carry;
    logic [32:0]  m_s;
    logic [31:0]  m_a, m_b;
    logic         m_c;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_carry <= '0;
        end else begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got id %0d sum %h, expected no result", resp_id, resp_sum);
                end else begin
                    m_exp = sb.pop_front();
                    check("sb_id", resp_id, m_exp.id);
                    check("sb_sum", resp_sum, m_exp.sum);
                    check("sb_cout", resp_cout, m_exp.cout);
                    check("sb_ovf", resp_ovf, m_exp.ovf);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m_a = req_a[32*i +: 32];
                    m_b = req_b[32*i +: 32];
                    m_c = req_cin[i];
`ifdef ADDER_RR_SCHED_CHAIN_EN
                    if (req_chain[i]) m_c = m_carry[i];
`endif
                    m_s = {1'b0, m_a} + {1'b0, m_b} + {32'd0, m_c};
`ifdef ADDER_RR_SCHED_CHAIN_EN
                    m_carry[i] <= m_s[32];
`endif
                    m_exp.id = 2'(i);
                    m_exp.sum = m_s[31:0];
                    m_exp.cout = m_s[32];
                    m_exp.ovf = (m_a[31] == m_b[31]) && (m_s[31] != m_a[31]);
                    sb.push_back(m_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin, input logic chain);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i] = cin;
        req_chain[i] = chain;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        req_chain = '0;
        resp_ready = 1'b1;
        req_valid = '1;
        vt[0] = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[1] = '{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[2] = '{2, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vt[3] = '{3, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vt[4] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[5] = '{2, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vt[6] = '{0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_id", resp_id, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_cout", resp_cout, 0);
        check("rst_ovf", resp_ovf, 0);
        req_valid = '0;
        rst = 1'b0;
        settle();

        foreach (vt[k]) begin
            set_req(vt[k].idx, vt[k].a, vt[k].b, vt[k].cin, 1'b0);
            settle();
            check("tbl_ready", req_ready, 64'd1 << vt[k].idx);
            tick();
            req_valid = '0;
            settle();
            check("tbl_valid", resp_valid, 1);
            check("tbl_id", resp_id, 64'(vt[k].idx));
            check("tbl_sum", resp_sum, vt[k].sum);
            check("tbl_cout", resp_cout, vt[k].cout);
            check("tbl_ovf", resp_ovf, vt[k].ovf);
            tick();
        end

        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom), 1'b0);
        settle();
        for (int k = 0; k < 6; k++) begin
            check("rr_grant", req_ready, 64'd1 << (k % N));
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        do_reset();
        set_req(0, 32'd5, 32'd6, 1'b0, 1'b0);
        settle();
        check("bp_grant0", req_ready, 1);
        tick();
        req_valid[0] = 1'b0;
        resp_ready = 1'b0;
        set_req(1, 32'd100, 32'd200, 1'b0, 1'b0);
        set_req(2, 32'd7, 32'd8, 1'b1, 1'b0);
        settle();
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", req_ready, 0);
            check("bp_valid", resp_valid, 1);
            check("bp_id", resp_id, 0);
            check("bp_sum", resp_sum, 11);
            tick();
        end
        resp_ready = 1'b1;
        settle();
        check("bp_release", req_ready, 2);
        tick();
        req_valid[1] = 1'b0;
        settle();
        check("bp_id1", resp_id, 1);
        check("bp_sum1", resp_sum, 300);
        check("bp_next", req_ready, 4);
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();

        do_reset();
        resp_ready = 1'b0;
        set_req(2, 32'd1, 32'd2, 1'b0, 1'b0);
        settle();
        check("rm_grant2", req_ready, 4);
        tick();
        req_valid[2] = 1'b0;
        set_req(1, 32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0);
        set_req(3, 32'h01010101, 32'h10101010, 1'b1, 1'b0);
        settle();
        check("rm_pend", resp_valid, 1);
        rst = 1'b1;
        resp_ready = 1'b1;
        settle();
        check("rm_ready_in_rst", req_ready, 0);
        tick();
        check("rm_valid", resp_valid, 0);
        check("rm_ready", req_ready, 0);
        rst = 1'b0;
        settle();
        check("rm_first", req_ready, 2);
        tick();
        req_valid[1] = 1'b0;
        settle();
        check("rm_second", req_ready, 8);
        tick();
        req_valid = '0;
        tick();
        tick();

        do_reset();
        set_req(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        settle();
        tick();
        req_valid[2] = 1'b0;
        settle();
        check("ch_lo_sum", resp_sum, 0);
        check("ch_lo_cout", resp_cout, 1);
        set_req(2, 32'h0, 32'h0, 1'b0, 1'b1);
        settle();
        tick();
        req_valid[2] = 1'b0;
        settle();
`ifdef ADDER_RR_SCHED_CHAIN_EN
        check("ch_hi_sum", resp_sum, 1);
`else
        check("ch_hi_sum", resp_sum, 0);
`endif
        tick();
        tick();

        check("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Shares one 32-bit carry-look-ahead adder instance (module adder) among NREQ requesters using round-robin arbitration.
- Each requester offers an operand pair through a valid/ready handshake.
- The winning pair passes through the shared adder; sum, carry-out and requester ID are registered into a single-entry output stage with backpressure.
- Sits between the functional-unit issue logic and the result bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  32*NREQ  operand A; requester i in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B; same packing.
- req_cin  in  NREQ  carry-in per requester.
- req_chain  in  NREQ  use the stored carry as Cin (optional feature only).
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  ID of the requester that produced the result.
- resp_sum  out  32  sum S.
- resp_cout  out  1  carry-out.
- resp_ovf  out  1  signed overflow: A[31]==B[31] and S[31]!=A[31].

Behaviour:
- Reset (rst=1 at a clock edge):
  - resp_valid=0; resp_id, resp_sum, resp_cout, resp_ovf = 0.
  - RR pointer = 0; all stored carries = 0.
  - req_ready is 0 while rst is high.
- Output state machine:
  - EMPTY (resp_valid=0) -> FULL on accept.
  - FULL with resp_ready=1 and a new accept -> FULL, register reloaded the same cycle (full throughput).
  - FULL with resp_ready=1 and no accept -> EMPTY.
  - FULL with resp_ready=0 -> FULL; outputs held stable.
- Slot-free condition: can_issue = !rst & (!resp_valid | resp_ready).
- Arbitration (combinational):
  - Search req_valid starting at the pointer index, ascending, wrapping at NREQ-1 -> 0.
  - First valid index g wins; req_ready[g] = can_issue.
  - All other req_ready bits are 0. With no valid request, all are 0.
- Accept: req_valid[g] & req_ready[g] at a clock edge.
  - The shared adder receives req_a[g], req_b[g], and Cin = req_cin[g].
  - resp_sum, resp_cout, resp_ovf and resp_id=g are registered at that edge.
  - Pointer <= (g+1) mod NREQ.
  - Latency: one cycle from accept to resp_valid.
- The pointer advances only on an accept. A blocked output or an idle cycle leaves it unchanged.
- Requester rules:
  - Requesters must hold valid and operands stable until accepted.
  - Dropping valid before accept is legal; the request is simply not served.
- Starvation bound: any continuously valid requester is accepted within NREQ accepts.
- Arithmetic: unsigned 32-bit sum modulo 2^32, cout = bit 32; matches A+B+Cin exactly.
- Reset asserted mid-transfer: a pending result is discarded (resp_valid=0 next cycle) and no accept occurs during reset.

Optional Feature:
- Macro: ADDER_RR_SCHED_CHAIN_EN.
- Defined:
  - One carry register per requester; on every accept of requester g, carry[g] <= resp_cout.
  - If req_chain[g]=1 at accept, Cin = carry[g] and req_cin[g] is ignored. This supports multi-word additions issued least-significant word first.
  - Carries from other requesters are never used.
- Undefined: req_chain is ignored, no carry registers exist, and Cin is always req_cin[g].

Test Plan:
1. Single request: reset, then req0 A=0xFFFFFFFF, B=0x00000001, cin=0. Required: accept in cycle 1; next cycle resp_valid=1, id=0, sum=0x00000000, cout=1, ovf=0.
2. Round-robin: all 4 requesters valid continuously, resp_ready=1. Required: accepts in order 0,1,2,3,0,1, one per cycle, with no idle cycle.
3. Backpressure: result pending with resp_ready=0 for 3 cycles while req1/req2 are valid. Required: all req_ready=0, outputs stable, pointer unchanged. After release, req1 is accepted the same cycle.
4. Overflow: A=0x7FFFFFFF, B=0x00000001, cin=0. Required: sum=0x80000000, cout=0, ovf=1. Also A=0x80000000, B=0x80000000. Required: sum=0, cout=1, ovf=1.
5. Reset mid-operation: rst=1 while resp_valid=1 and requests pending. Required: next cycle resp_valid=0 and all req_ready=0. After rst drops, the first grant goes to the lowest valid index from pointer 0.
6. (CHAIN_EN) 64-bit add on req2: low word 0xFFFFFFFF+0x1 with chain=0, then high word 0x0+0x0 with chain=1 and req_cin=0. Required: high sum=0x00000001. Without the macro the same stimulus gives high sum=0x00000000.
